// File: rtl/jtag_tap_core.sv
// -----------------------------------------------------------------------------
// jtag_tap_core
//
// IEEE 1149.1 TAP controller with its own instruction register, BYPASS
// register, 32-bit IDCODE register and TDO multiplexer. The active instruction
// is decoded into one-hot select lines for NUM_USER external user data
// registers, which are driven by the CaptureDR / ShiftDR / UpdateDR levels.
//
// Ports
//   TCK        in   test clock; state changes on posedge, TDO on negedge
//   reset_bar  in   asynchronous active-low TAP reset (TRST)
//   TMS        in   test mode select, sampled on posedge TCK
//   TDI        in   test data in, sampled on posedge TCK
//   TDO        out  test data out, registered on negedge TCK
//   enable_TDO out  TDO output enable, high in SHIFT_DR / SHIFT_IR
//   tap_state  out  current FSM state (0 = TEST_LOGIC_RESET .. F = UPDATE_IR)
//   ir_out     out  currently active instruction
//   test_rst   out  high while in TEST_LOGIC_RESET
//   sel_user   out  one-hot user data register select
//   CaptureDR  out  high in CAPTURE_DR while a user DR is selected
//   ShiftDR    out  high in SHIFT_DR while a user DR is selected
//   UpdateDR   out  high in UPDATE_DR while a user DR is selected
//   user_tdo   in   serial outputs of the user DRs (LSB first)
//
// Handshakes: none. User logic samples the strobe levels on posedge TCK.
// -----------------------------------------------------------------------------
module jtag_tap_core #(
  parameter int                  IR_WIDTH      = 4,
  parameter logic [31:0]         IDCODE_VAL    = 32'h0BA0_0477,
  parameter logic [IR_WIDTH-1:0] IDCODE_OPC    = IR_WIDTH'(1),
  parameter int                  NUM_USER      = 2,
  parameter logic [IR_WIDTH-1:0] USER_OPC_BASE = IR_WIDTH'(2)
) (
  input  logic                TCK,
  input  logic                reset_bar,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                enable_TDO,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_out,
  output logic                test_rst,
  output logic [NUM_USER-1:0] sel_user,
  output logic                CaptureDR,
  output logic                ShiftDR,
  output logic                UpdateDR,
  input  logic [NUM_USER-1:0] user_tdo
);

  typedef enum logic [3:0] {
    TLR    = 4'h0,
    RTI    = 4'h1,
    SEL_DR = 4'h2,
    CAP_DR = 4'h3,
    SH_DR  = 4'h4,
    EX1_DR = 4'h5,
    PA_DR  = 4'h6,
    EX2_DR = 4'h7,
    UPD_DR = 4'h8,
    SEL_IR = 4'h9,
    CAP_IR = 4'hA,
    SH_IR  = 4'hB,
    EX1_IR = 4'hC,
    PA_IR  = 4'hD,
    EX2_IR = 4'hE,
    UPD_IR = 4'hF
  } tap_state_t;

  tap_state_t          r_state;
  logic [IR_WIDTH-1:0] r_ir_sr;
  logic [IR_WIDTH-1:0] r_ir_hold;
  logic                r_bypass;
  logic [31:0]         r_idcode;
  logic                r_tdo;
  logic                r_en;

  logic                w_all_ones;
  logic                w_sel_idcode;
  logic                w_sel_bypass;
  logic                w_any_user;
  logic                w_user_bit;

  // ---------------------------------------------------------------------------
  // TAP state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge TCK or negedge reset_bar) begin
    if (!reset_bar) begin
      r_state <= TLR;
    end else begin
      case (r_state)
        TLR:    r_state <= TMS ? TLR    : RTI;
        RTI:    r_state <= TMS ? SEL_DR : RTI;
        SEL_DR: r_state <= TMS ? SEL_IR : CAP_DR;
        CAP_DR: r_state <= TMS ? EX1_DR : SH_DR;
        SH_DR:  r_state <= TMS ? EX1_DR : SH_DR;
        EX1_DR: r_state <= TMS ? UPD_DR : PA_DR;
        PA_DR:  r_state <= TMS ? EX2_DR : PA_DR;
        EX2_DR: r_state <= TMS ? UPD_DR : SH_DR;
        UPD_DR: r_state <= TMS ? SEL_DR : RTI;
        SEL_IR: r_state <= TMS ? TLR    : CAP_IR;
        CAP_IR: r_state <= TMS ? EX1_IR : SH_IR;
        SH_IR:  r_state <= TMS ? EX1_IR : SH_IR;
        EX1_IR: r_state <= TMS ? UPD_IR : PA_IR;
        PA_IR:  r_state <= TMS ? EX2_IR : PA_IR;
        EX2_IR: r_state <= TMS ? UPD_IR : SH_IR;
        UPD_IR: r_state <= TMS ? SEL_DR : RTI;
      endcase
    end
  end

  assign tap_state = r_state;
  assign test_rst  = (r_state == TLR);

  // ---------------------------------------------------------------------------
  // Instruction register
  // ---------------------------------------------------------------------------
  // Capture pattern: bit0 = 1, bit1 = 0, all upper bits 0.
  always_ff @(posedge TCK or negedge reset_bar) begin
    if (!reset_bar) begin
      r_ir_sr <= '0;
    end else if (r_state == CAP_IR) begin
      r_ir_sr <= IR_WIDTH'(1);
    end else if (r_state == SH_IR) begin
      r_ir_sr <= {TDI, r_ir_sr[IR_WIDTH-1:1]};
    end
  end

  // The active instruction updates on the negedge in UPDATE_IR. Entering TLR
  // must show IDCODE on the very posedge that enters it, so TLR overrides the
  // held value combinationally; the hold register picks up IDCODE_OPC on the
  // following negedge, so leaving TLR keeps it.
  always_ff @(negedge TCK or negedge reset_bar) begin
    if (!reset_bar) begin
      r_ir_hold <= IDCODE_OPC;
    end else if (r_state == TLR) begin
      r_ir_hold <= IDCODE_OPC;
    end else if (r_state == UPD_IR) begin
      r_ir_hold <= r_ir_sr;
    end
  end

  assign ir_out = (r_state == TLR) ? IDCODE_OPC : r_ir_hold;

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  assign w_all_ones   = &ir_out;
  assign w_sel_idcode = (ir_out == IDCODE_OPC);

  // All-ones is always BYPASS, even if a user opcode would alias onto it.
  for (genvar g = 0; g < NUM_USER; g++) begin : g_user_dec
    assign sel_user[g] = (ir_out == (USER_OPC_BASE + IR_WIDTH'(g))) &&
                         !w_all_ones && !w_sel_idcode;
  end

  assign w_any_user   = |sel_user;
  assign w_sel_bypass = !w_sel_idcode && !w_any_user;
  assign w_user_bit   = |(sel_user & user_tdo);

  assign CaptureDR = (r_state == CAP_DR) && w_any_user;
  assign ShiftDR   = (r_state == SH_DR)  && w_any_user;
  assign UpdateDR  = (r_state == UPD_DR) && w_any_user;

  // ---------------------------------------------------------------------------
  // BYPASS and IDCODE data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge TCK or negedge reset_bar) begin
    if (!reset_bar) begin
      r_bypass <= 1'b0;
    end else if (r_state == CAP_DR) begin
      r_bypass <= 1'b0;
    end else if (r_state == SH_DR && w_sel_bypass) begin
      r_bypass <= TDI;
    end
  end

  always_ff @(posedge TCK or negedge reset_bar) begin
    if (!reset_bar) begin
      r_idcode <= IDCODE_VAL;
    end else if (r_state == CAP_DR && w_sel_idcode) begin
      r_idcode <= IDCODE_VAL;
    end else if (r_state == SH_DR && w_sel_idcode) begin
      r_idcode <= {TDI, r_idcode[31:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // TDO mux, registered on the falling edge
  // ---------------------------------------------------------------------------
  always_ff @(negedge TCK or negedge reset_bar) begin
    if (!reset_bar) begin
      r_tdo <= 1'b0;
      r_en  <= 1'b0;
    end else if (r_state == SH_IR) begin
      r_tdo <= r_ir_sr[0];
      r_en  <= 1'b1;
    end else if (r_state == SH_DR) begin
      r_en  <= 1'b1;
      if (w_sel_idcode) begin
        r_tdo <= r_idcode[0];
      end else if (w_any_user) begin
        r_tdo <= w_user_bit;
      end else begin
        r_tdo <= r_bypass;
      end
    end else begin
      r_tdo <= 1'b0;
      r_en  <= 1'b0;
    end
  end

  assign TDO        = r_tdo;
  assign enable_TDO = r_en;

endmodule

// File: tb/tb_jtag_tap_core.sv
// -----------------------------------------------------------------------------
// tb_jtag_tap_core
//
// Self-checking bench for jtag_tap_core. A reference model built from the
// TAP transition table and bit queues for the IR / DR chains predicts every
// output after each posedge and negedge of TCK.
// -----------------------------------------------------------------------------
module tb_jtag_tap_core;

  localparam int W = 4;

  logic         TCK;
  logic         reset_bar;
  logic         TMS;
  logic         TDI;
  logic         TDO;
  logic         enable_TDO;
  logic [3:0]   tap_state;
  logic [W-1:0] ir_out;
  logic         test_rst;
  logic [1:0]   sel_user;
  logic         CaptureDR;
  logic         ShiftDR;
  logic         UpdateDR;
  logic [1:0]   user_tdo;

  jtag_tap_core dut (
    .TCK        (TCK),
    .reset_bar  (reset_bar),
    .TMS        (TMS),
    .TDI        (TDI),
    .TDO        (TDO),
    .enable_TDO (enable_TDO),
    .tap_state  (tap_state),
    .ir_out     (ir_out),
    .test_rst   (test_rst),
    .sel_user   (sel_user),
    .CaptureDR  (CaptureDR),
    .ShiftDR    (ShiftDR),
    .UpdateDR   (UpdateDR),
    .user_tdo   (user_tdo)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  // Next state for TMS=0 / TMS=1, indexed by state number.
  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  logic [31:0]  idv = 32'h0BA0_0477;
  int           m_state;
  logic [W-1:0] m_ir;
  bit           ir_q[$];
  bit           dr_q[$];

  function automatic logic [1:0] m_sel(input logic [W-1:0] ir);
    logic [1:0] s;
    s = 2'b00;
    if (ir == 4'h2) s = 2'b01;
    if (ir == 4'h3) s = 2'b10;
    return s;
  endfunction

  function automatic void model_reset();
    m_state = 0;
    m_ir    = 4'h1;
    ir_q.delete();
    for (int i = 0; i < W; i++) ir_q.push_back(1'b0);
    dr_q.delete();
  endfunction

  function automatic void model_pos();
    logic [1:0] s;
    s = m_sel(m_ir);
    case (m_state)
      3: begin
        dr_q.delete();
        if (m_ir == 4'h1) begin
          for (int i = 0; i < 32; i++) dr_q.push_back(idv[i]);
        end else if (s == 2'b00) begin
          dr_q.push_back(1'b0);
        end
      end
      4: begin
        if (dr_q.size() > 0) begin
          void'(dr_q.pop_front());
          dr_q.push_back(TDI);
        end
      end
      10: begin
        ir_q.delete();
        ir_q.push_back(1'b1);
        for (int i = 1; i < W; i++) ir_q.push_back(1'b0);
      end
      11: begin
        void'(ir_q.pop_front());
        ir_q.push_back(TDI);
      end
      default: ;
    endcase
    m_state = TMS ? nxt1[m_state] : nxt0[m_state];
    if (m_state == 0) m_ir = 4'h1;
  endfunction

  logic exp_tdo;
  logic exp_en;

  function automatic void model_neg();
    logic [1:0] s;
    if (m_state == 15) begin
      for (int i = 0; i < W; i++) m_ir[i] = ir_q[i];
    end
    s = m_sel(m_ir);
    exp_en  = (m_state == 4) || (m_state == 11);
    exp_tdo = 1'b0;
    if (m_state == 11) exp_tdo = ir_q[0];
    else if (m_state == 4) exp_tdo = (s != 2'b00) ? |(s & user_tdo) : dr_q[0];
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (called just after a negedge, return just after a negedge)
  // ---------------------------------------------------------------------------
  logic last_tdo;
  logic last_en;
  logic [1:0] last_utdo;
  int cnt_cap, cnt_sh, cnt_upd;

  task automatic cycle(input bit tms, input bit tdi);
    logic [1:0] s;
    TMS      = tms;
    TDI      = tdi;
    user_tdo = 2'($urandom_range(0, 3));
    @(posedge TCK);
    model_pos();
    #1;
    s = m_sel(m_ir);
    chk("tap_state", 32'(tap_state), 32'(m_state));
    chk("test_rst",  32'(test_rst),  32'(m_state == 0));
    chk("ir_out_p",  32'(ir_out),    32'(m_ir));
    chk("sel_user",  32'(sel_user),  32'(s));
    chk("CaptureDR", 32'(CaptureDR), 32'(m_state == 3 && s != 2'b00));
    chk("ShiftDR",   32'(ShiftDR),   32'(m_state == 4 && s != 2'b00));
    chk("UpdateDR",  32'(UpdateDR),  32'(m_state == 8 && s != 2'b00));
    cnt_cap += int'(CaptureDR);
    cnt_sh  += int'(ShiftDR);
    cnt_upd += int'(UpdateDR);
    @(negedge TCK);
    model_neg();
    #1;
    chk("TDO",        32'(TDO),        32'(exp_tdo));
    chk("enable_TDO", 32'(enable_TDO), 32'(exp_en));
    chk("ir_out_n",   32'(ir_out),     32'(m_ir));
    last_tdo  = TDO;
    last_en   = enable_TDO;
    last_utdo = user_tdo;
  endtask

  task automatic do_reset();
    reset_bar = 1'b0;
    #2;
    model_reset();
    chk("rst_state", 32'(tap_state), 32'h0);
    chk("rst_ir",    32'(ir_out),    32'h1);
    chk("rst_en",    32'(enable_TDO), 32'h0);
    chk("rst_tdo",   32'(TDO),        32'h0);
    chk("rst_strb",  32'({CaptureDR, ShiftDR, UpdateDR}), 32'h0);
    chk("rst_trst",  32'(test_rst),   32'h1);
    @(negedge TCK);
    #1;
    reset_bar = 1'b1;
  endtask

  // Starts and ends in RUN_TEST_IDLE; returns the bits shifted out of IR.
  task automatic ir_scan(input logic [W-1:0] opc, output logic [W-1:0] cap);
    int k;
    k   = 0;
    cap = '0;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    if (last_en && k < W) begin cap[k] = last_tdo; k++; end
    for (int i = 0; i < W; i++) begin
      cycle(i == W - 1, opc[i]);
      if (last_en && k < W) begin cap[k] = last_tdo; k++; end
    end
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
  endtask

  int n_follow;
  int follow_idx;

  task automatic dr_scan(input logic [63:0] data, input int len,
                         output logic [63:0] got, output int n_en);
    got      = '0;
    n_en     = 0;
    n_follow = 0;
    cnt_cap  = 0;
    cnt_sh   = 0;
    cnt_upd  = 0;
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    if (last_en && n_en < 64) begin
      got[n_en] = last_tdo;
      n_en++;
      if (last_tdo == last_utdo[follow_idx]) n_follow++;
    end
    for (int i = 0; i < len; i++) begin
      cycle(i == len - 1, data[i]);
      if (last_en && n_en < 64) begin
        got[n_en] = last_tdo;
        n_en++;
        if (last_tdo == last_utdo[follow_idx]) n_follow++;
      end
    end
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
  endtask

  // TMS paths from TLR to each state, bit i applied i-th.
  logic [7:0] path_bits[16] = '{8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h0A, 8'h0A, 8'h2A,
                                8'h1A, 8'h06, 8'h06, 8'h06, 8'h16, 8'h16, 8'h56, 8'h36};
  int         path_len[16]  = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [W-1:0] cap;
    logic [63:0]  got;
    logic [63:0]  data;
    logic [7:0]   pb;
    int           n_en;
    int           len;

    TMS        = 1'b1;
    TDI        = 1'b0;
    user_tdo   = 2'b00;
    reset_bar  = 1'b0;
    follow_idx = 0;
    cnt_cap    = 0;
    cnt_sh     = 0;
    cnt_upd    = 0;
    model_reset();
    @(negedge TCK);
    #1;
    do_reset();

    // IDCODE read straight after reset: TMS 0,1,0,0 then 32 shifts.
    cycle(1'b0, 1'b0);
    dr_scan({$urandom, $urandom}, 32, got, n_en);
    chk("idcode_val", got[31:0], 32'h0BA0_0477);
    chk("idcode_en",  32'(n_en), 32'd32);

    // IR scan of all-ones -> BYPASS.
    ir_scan(4'hF, cap);
    chk("ir_capture", 32'(cap),    32'h1);
    chk("ir_F",       32'(ir_out), 32'hF);
    dr_scan(64'hD, 4, got, n_en);
    chk("bypass_F",   32'(got[3:0]), 32'hA);
    chk("bypass_strb", 32'(cnt_cap + cnt_sh + cnt_upd), 32'd0);

    // Undecoded opcode behaves as BYPASS.
    ir_scan(4'h6, cap);
    chk("ir_6",     32'(ir_out),   32'h6);
    chk("sel_6",    32'(sel_user), 32'h0);
    dr_scan(64'hD, 4, got, n_en);
    chk("bypass_6", 32'(got[3:0]), 32'hA);

    // User DR 1.
    ir_scan(4'h3, cap);
    chk("sel_3", 32'(sel_user), 32'h2);
    follow_idx = 1;
    dr_scan({$urandom, $urandom}, 8, got, n_en);
    chk("u1_cap",    32'(cnt_cap),  32'd1);
    chk("u1_shift",  32'(cnt_sh),   32'd8);
    chk("u1_upd",    32'(cnt_upd),  32'd1);
    chk("u1_follow", 32'(n_follow), 32'(n_en));
    chk("u1_len",    32'(n_en),     32'd8);

    // User DR 0.
    ir_scan(4'h2, cap);
    chk("sel_2", 32'(sel_user), 32'h1);
    follow_idx = 0;
    dr_scan({$urandom, $urandom}, 6, got, n_en);
    chk("u0_follow", 32'(n_follow), 32'(n_en));
    chk("u0_len",    32'(n_en),     32'd6);

    // Reset in the middle of a DR shift.
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    chk("pre_rst_en", 32'(last_en), 32'h1);
    do_reset();

    // Five TMS=1 edges reach TLR from every state.
    for (int s = 0; s < 16; s++) begin
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
      pb = path_bits[s];
      for (int i = 0; i < path_len[s]; i++) cycle(pb[i], 1'($urandom_range(0, 1)));
      chk("path_state", 32'(tap_state), 32'(s));
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'($urandom_range(0, 1)));
      chk("tlr5_state", 32'(tap_state), 32'h0);
      chk("tlr5_trst",  32'(test_rst),  32'h1);
      chk("tlr5_ir",    32'(ir_out),    32'h1);
    end

    // Random IR / DR scans.
    cycle(1'b0, 1'b0);
    for (int r = 0; r < 25; r++) begin
      ir_scan(4'($urandom_range(0, 15)), cap);
      chk("rnd_ircap", 32'(cap), 32'h1);
      len  = $urandom_range(1, 40);
      data = {$urandom, $urandom};
      follow_idx = 0;
      dr_scan(data, len, got, n_en);
      chk("rnd_drlen", 32'(n_en), 32'(len));
    end

    // Random TMS walk with occasional resets.
    for (int r = 0; r < 800; r++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
